aes128_encryption_block: RTL and testbench
==========================================

# aes128_encryption_block

Iterative AES-128 encryption core (FIPS-197) that encrypts one 128-bit block with a 128-bit key per operation. It computes one cipher round per clock with on-the-fly key expansion and holds the ciphertext on a registered output until the next operation completes. It sits between the datapath that supplies plaintext/key and any consumer that samples the ciphertext at a known latency.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  reset; one clock, reset is asynchronous and active-low.
- encryptEnable  input  1  level request; start an operation when high while idle.
- key  input  128  cipher key; bits [127:120] = key byte 0.
- inputData  input  128  plaintext; bits [127:120] = state byte 0 (s[0,0]), column-major.
- outputData  output  128  registered ciphertext, same byte order.

## Operation
- Standard AES-128: initial AddRoundKey, rounds 1–9 (SubBytes, ShiftRows, MixColumns, AddRoundKey), round 10 without MixColumns.
- Key schedule on the fly: a round-key register starts at key; each round derives the next key (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1B,36).
- S-box: 16 data-path instances plus 4 key-path instances, as a lookup table or a composite-field implementation.
- FSM states: IDLE, ROUND.
  - IDLE: if encryptEnable=1, state <= inputData ^ key, round key <= expansion of key for round 1, round counter <= 1, go to ROUND. Otherwise hold.
  - ROUND: apply round at counter value; counter increments. When counter = 10, write final result to outputData, go to IDLE.
- key and inputData are sampled only on the IDLE start edge; later changes are ignored until the next start.
- encryptEnable held high: the block restarts from IDLE on the edge after completion, re-sampling key/inputData each time. Continuous back-to-back operation is legal.
- Deasserting encryptEnable mid-operation does not abort; the operation completes.
- outputData changes only at completion of round 10. It holds its value otherwise, including while idle.

## Timing
- Reset (n_rst=0, asynchronous): FSM=IDLE, counter=0, internal state/round key=0, outputData=128'h0. Any operation in flight is aborted and no output is written.
- Start edge S (IDLE, encryptEnable=1): operands captured.
- Rounds 1..10 execute at edges S+1..S+10. outputData is valid after edge S+10 (latency 10 cycles). FSM is in IDLE after S+10.
- With encryptEnable still high, the next start edge is S+11 (throughput 11 cycles/block).
- Guarantee for users: operands that are stable from any falling edge onward produce their ciphertext on outputData no later than 22 rising edges later, even when encryptEnable has been high continuously.
- Release of n_rst with encryptEnable=1: the first start occurs on the first rising edge with n_rst=1.

## Test plan
- Reset: assert n_rst=0 mid-operation -> outputData=0 immediately. FSM returns to IDLE, and no stale write occurs after release.
- FIPS-197 vector: key 000102030405060708090A0B0C0D0E0F, inputData 00112233445566778899AABBCCDDEEFF, enable pulse -> outputData=69C4E0D86A7B0430D8CDB78070B4C55A exactly 10 cycles after the start edge, held thereafter.
- Back-to-back with encryptEnable held high: key 5E74E7BA66B0C7CC1B7697B3F9F51527 / data 7D8AE0F7CFA0A6CB09FB5D05A8EC586D -> DEB0F81341F3503A7CD01E2BC7CDD556. Then change to key 33DE20E331BA5A525AB7C2495A767B5A / data E6FEBF30133874EBCB49226CD36D0D4F -> 67928DD5470D4A11F0EA4AE7D49B2DD4 within 22 cycles.
- Operand change mid-operation: key EED5A3496E321A41C925F0389B236E36 / data D07A7228CF5E1ED034E14FA06FA08D49 captured, then key/data changed at cycle S+5 -> outputData still 71D31B8BA309FF7ABF61A6938CFA4267 at S+10.
- Reset between operations, then key AD711EC0ACD35F80C3E5EDD4E1336B6A / data C0C148CF7C52DC9A10CCAB979FF03920 -> 0EA6416862183B71C5A2B66E320FDDEB.
- Enable low: encryptEnable=0 for 50 cycles with changing operands -> outputData unchanged.

Source files
------------

// File: rtl/aes128_encryption_block.sv
// AES-128 encryption core: one cipher round per clock, on-the-fly key
// expansion, ciphertext held on a registered output between operations.

// 8-bit AES S-box as a constant lookup table.
module aes128_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];
endmodule

module aes128_encryption_block (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         encryptEnable,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic [127:0] outputData
);
  typedef enum logic {IDLE, ROUND} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   cnt_q;
  logic [127:0] state_q, rkey_q;

  // State viewed as 16 bytes, element 0 = s[0,0] in the top byte.
  logic [0:15][7:0] st_b, sb, sr, mc;
  logic [127:0]     round_out;
  logic             last_round;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign st_b = state_q;

  // ---------------- data path: SubBytes / ShiftRows / MixColumns
  genvar gi, gr, gc;
  for (gi = 0; gi < 16; gi++) begin : g_dsbox
    aes128_sbox u_sbox (.a(st_b[gi]), .y(sb[gi]));
  end

  for (gc = 0; gc < 4; gc++) begin : g_col
    // Row r rotates left by r columns.
    for (gr = 0; gr < 4; gr++) begin : g_row
      assign sr[gr + 4*gc] = sb[gr + 4*((gc + gr) % 4)];
    end
    assign mc[4*gc]   = xt(sr[4*gc]) ^ xt(sr[4*gc+1]) ^ sr[4*gc+1] ^ sr[4*gc+2] ^ sr[4*gc+3];
    assign mc[4*gc+1] = sr[4*gc] ^ xt(sr[4*gc+1]) ^ xt(sr[4*gc+2]) ^ sr[4*gc+2] ^ sr[4*gc+3];
    assign mc[4*gc+2] = sr[4*gc] ^ sr[4*gc+1] ^ xt(sr[4*gc+2]) ^ xt(sr[4*gc+3]) ^ sr[4*gc+3];
    assign mc[4*gc+3] = xt(sr[4*gc]) ^ sr[4*gc] ^ sr[4*gc+1] ^ sr[4*gc+2] ^ xt(sr[4*gc+3]);
  end

  // Round 10 skips MixColumns.
  assign last_round = (cnt_q == 4'd10);
  assign round_out  = (last_round ? sr : mc) ^ rkey_q;

  // ---------------- key path: one expander shared by start and rounds
  // While idle it expands the incoming key into round key 1; during
  // rounds it advances the round-key register to the next round.
  logic [127:0] kin, key_next;
  logic [31:0]  rot, subw, tmp, n0, n1, n2, n3;
  logic [3:0]   rnd_idx;

  assign kin     = (fsm_q == IDLE) ? key : rkey_q;
  assign rnd_idx = (fsm_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
  assign rot     = {kin[23:0], kin[31:24]};

  for (gi = 0; gi < 4; gi++) begin : g_ksbox
    aes128_sbox u_sbox (.a(rot[31-8*gi -: 8]), .y(subw[31-8*gi -: 8]));
  end

  assign tmp      = subw ^ {rcon(rnd_idx), 24'h0};
  assign n0       = kin[127:96] ^ tmp;
  assign n1       = kin[95:64]  ^ n0;
  assign n2       = kin[63:32]  ^ n1;
  assign n3       = kin[31:0]   ^ n2;
  assign key_next = {n0, n1, n2, n3};

  // ---------------- control
  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // Next state: start on enable while idle, return to idle after round 10.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (encryptEnable) fsm_d = ROUND;
      ROUND:   if (last_round)    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Round state, round key, counter and the held ciphertext.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q      <= 4'd0;
      state_q    <= '0;
      rkey_q     <= '0;
      outputData <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (encryptEnable) begin
            state_q <= inputData ^ key;
            rkey_q  <= key_next;
            cnt_q   <= 4'd1;
          end
        end
        ROUND: begin
          state_q <= round_out;
          rkey_q  <= key_next;
          if (last_round) begin
            outputData <= round_out;
            cnt_q      <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: cnt_q <= 4'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_encryption_block.sv
// Bench for aes128_encryption_block: known-answer vectors, latency and
// hold behaviour, resets, and random blocks against a byte-level model.
module tb_aes128_encryption_block;
  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         en = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] data = '0;
  logic [127:0] out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ref_sbox [256];

  aes128_encryption_block dut (
    .clk(clk), .n_rst(n_rst), .encryptEnable(en),
    .key(key), .inputData(data), .outputData(out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box derived from the field inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] xb, yb, inv, b;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (xb != 8'h00 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      b = inv;
      ref_sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [31:0]  tw;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {ref_sbox[tw[23:16]], ref_sbox[tw[15:8]], ref_sbox[tw[7:0]], ref_sbox[tw[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) st[q+4*c] = t[q + 4*((c+q)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scenarios
  task automatic test_reset();
    n_rst = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_value: got %h want %h", out, 128'h0);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h want %h", out, 128'h0);
    end
  endtask

  task automatic test_fips();
    logic [127:0] exp;
    exp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    @(negedge clk);
    key = 128'h000102030405060708090a0b0c0d0e0f;
    data = 128'h00112233445566778899aabbccddeeff; en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL fips_early: got %h want %h", out, 128'h0);
    end
    @(negedge clk);
    vectors++;
    if (out !== exp) begin
      miscompares++;
      $display("FAIL fips_latency10: got %h want %h", out, exp);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (out !== exp) begin
      miscompares++;
      $display("FAIL fips_hold: got %h want %h", out, exp);
    end
  endtask

  task automatic test_operand_change();
    logic [127:0] prev, exp;
    exp = 128'h71d31b8ba309ff7abf61a6938cfa4267;
    prev = out;
    @(negedge clk);
    key = 128'heed5a3496e321a41c925f0389b236e36;
    data = 128'hd07a7228cf5e1ed034e14fa06fa08d49; en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (5) @(negedge clk);
    key = rnd128(); data = rnd128();
    repeat (4) @(negedge clk);
    vectors++;
    if (out !== prev) begin
      miscompares++;
      $display("FAIL opchg_early: got %h want %h", out, prev);
    end
    @(negedge clk);
    vectors++;
    if (out !== exp) begin
      miscompares++;
      $display("FAIL opchg_result: got %h want %h", out, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp, prev, k, d;
    int waited;
    bit found;
    @(negedge clk);
    key = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;
    data = 128'h7d8ae0f7cfa0a6cb09fb5d05a8ec586d; en = 1'b1;
    repeat (11) @(negedge clk);
    vectors++;
    if (out !== 128'hdeb0f81341f3503a7cd01e2bc7cdd556) begin
      miscompares++;
      $display("FAIL b2b_first: got %h want %h", out, 128'hdeb0f81341f3503a7cd01e2bc7cdd556);
    end
    key = 128'h33de20e331ba5a525ab7c2495a767b5a;
    data = 128'he6febf30133874ebcb49226cd36d0d4f;
    exp = 128'h67928dd5470d4a11f0ea4ae7d49b2dd4;
    found = 1'b0; waited = 0;
    while (!found && waited < 22) begin
      @(negedge clk); waited++;
      if (out === exp) found = 1'b1;
    end
    vectors++;
    if (!found || waited != 11) begin
      miscompares++;
      $display("FAIL b2b_second: got %h after %0d cycles want %h after 11", out, waited, exp);
    end
    // Keep enable high; new random operands each time a block lands.
    for (int n = 0; n < 6; n++) begin
      k = rnd128(); d = rnd128();
      key = k; data = d; prev = out;
      exp = aes_ref(k, d);
      repeat (10) @(negedge clk);
      vectors++;
      if (out !== prev) begin
        miscompares++;
        $display("FAIL b2b_rand_early[%0d]: got %h want %h", n, out, prev);
      end
      @(negedge clk);
      vectors++;
      if (out !== exp) begin
        miscompares++;
        $display("FAIL b2b_rand[%0d]: got %h want %h", n, out, exp);
      end
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [127:0] prev;
    prev = out;
    @(negedge clk);
    key = rnd128(); data = rnd128(); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (out !== prev) begin
      miscompares++;
      $display("FAIL midop_before_reset: got %h want %h", out, prev);
    end
    n_rst = 1'b0;
    #1;
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL midop_async_clear: got %h want %h", out, 128'h0);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (14) @(negedge clk);
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL midop_no_stale_write: got %h want %h", out, 128'h0);
    end
  endtask

  task automatic test_reset_between();
    logic [127:0] exp;
    exp = 128'h0ea6416862183b71c5a2b66e320fddeb;
    @(negedge clk);
    key = 128'h000102030405060708090a0b0c0d0e0f;
    data = 128'h00112233445566778899aabbccddeeff; en = 1'b1;
    repeat (11) @(negedge clk);
    en = 1'b0;
    n_rst = 1'b0;
    #1;
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL between_clear: got %h want %h", out, 128'h0);
    end
    key = 128'had711ec0acd35f80c3e5edd4e1336b6a;
    data = 128'hc0c148cf7c52dc9a10ccab979ff03920; en = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (out !== 128'h0) begin
      miscompares++;
      $display("FAIL between_early: got %h want %h", out, 128'h0);
    end
    @(negedge clk);
    vectors++;
    if (out !== exp) begin
      miscompares++;
      $display("FAIL between_result: got %h want %h", out, exp);
    end
  endtask

  task automatic test_enable_low();
    logic [127:0] prev;
    prev = out;
    en = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      key = rnd128(); data = rnd128();
      vectors++;
      if (out !== prev) begin
        miscompares++;
        $display("FAIL enable_low_hold[%0d]: got %h want %h", n, out, prev);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] k, d, exp, prev;
    for (int n = 0; n < 12; n++) begin
      k = rnd128(); d = rnd128();
      exp = aes_ref(k, d);
      prev = out;
      @(negedge clk);
      key = k; data = d; en = 1'b1;
      @(negedge clk);
      en = 1'b0; key = rnd128(); data = rnd128();
      repeat (9) @(negedge clk);
      vectors++;
      if (out !== prev) begin
        miscompares++;
        $display("FAIL random_early[%0d]: got %h want %h", n, out, prev);
      end
      @(negedge clk);
      vectors++;
      if (out !== exp) begin
        miscompares++;
        $display("FAIL random_result[%0d]: key %h pt %h got %h want %h", n, k, d, out, exp);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_operand_change();
    test_back_to_back();
    test_reset_midop();
    test_reset_between();
    test_enable_low();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end
endmodule
